output_arbiter: RTL
===================

OUTPUT_ARBITER -- requirements
Module: output_arbiter

Interface
REQ-001 Parameter NUM_CH, default 3: number of channel FIFOs served.
REQ-002 Parameter DATA_WD, default 8: byte width of the FIFO data and the output data.
REQ-003 Parameter LEN_WD, default 6: width of the header length field, header bits [LEN_WD-1:0].
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 ch_en  in  NUM_CH  per-channel enable; a disabled channel is never newly granted.
REQ-007 fifo_empty  in  NUM_CH  empty flag of each channel FIFO.
REQ-008 fifo_data  in  NUM_CH*DATA_WD  head byte of each FIFO; channel i occupies bits [i*DATA_WD +: DATA_WD].
REQ-009 fifo_pop  out  NUM_CH  one-hot pop strobe; each asserted cycle consumes the head byte.
REQ-010 out_data  out  DATA_WD  current byte of the granted channel.
REQ-011 out_valid  out  1  out_data is valid.
REQ-012 out_ready  in  1  downstream accepts the byte; a beat transfers on out_valid && out_ready.
REQ-013 out_sop / out_eop  out  1 each  first byte (header) / last byte (CRC) of the packet.
REQ-014 out_ch  out  clog2(NUM_CH)  index of the granted channel; valid while busy.
REQ-015 busy  out  1  a packet transfer is in progress (state XFER).

Function
REQ-016 Packet format: header byte with payload length N = header[LEN_WD-1:0], then N payload bytes, then 1 CRC byte; total N+2 bytes; N=0 gives 2 bytes.
REQ-017 Only committed packets are visible in a FIFO, so a non-empty FIFO holds at least one whole packet.
REQ-018 State machine has two states: IDLE and XFER.
REQ-019 IDLE: if any channel i has ch_en[i]=1 and fifo_empty[i]=0, grant the first such i in round-robin order starting at last_grant+1 (mod NUM_CH), register out_ch, and enter XFER on the next cycle.
REQ-020 IDLE: if no channel qualifies, remain in IDLE; arbitration latency is 1 cycle from request to the first out_valid.
REQ-021 XFER: out_valid = !fifo_empty[out_ch]; out_data = fifo_data[out_ch] (combinational, no added latency).
REQ-022 fifo_pop[out_ch] = out_valid && out_ready in XFER; all other pop bits are 0, and all pop bits are 0 in IDLE.
REQ-023 On the first transfer beat: out_sop=1, and the remaining-beat counter loads N+1.
REQ-024 On each later beat the counter decrements; out_eop=1 when the counter equals 1 on a non-first beat.
REQ-025 Counter width is LEN_WD+1 bits, so N=2^LEN_WD-1 gives N+1 with no overflow.
REQ-026 On the eop beat: last_grant <= out_ch and the state returns to IDLE; there is a 1-cycle IDLE gap between packets.
REQ-027 If the FIFO goes empty mid-packet, out_valid=0 and the block stalls in XFER; no pop is issued and the counter holds.
REQ-028 Deasserting ch_en during XFER does not abort the current packet.
REQ-029 out_valid, once asserted, holds out_data stable until the transfer completes (FIFO head is stable while it is not popped).
REQ-030 No combinational path from out_ready to out_valid.

Reset
REQ-031 rst=1 at a clock edge forces state=IDLE, counter=0, out_ch=0, last_grant=NUM_CH-1 (so channel 0 has first priority).
REQ-032 During and after reset: fifo_pop=0, out_valid=0, out_sop=0, out_eop=0, busy=0.
REQ-033 Reset mid-packet abandons the packet with no further pops; FIFO recovery is the system's responsibility.

Structure
REQ-034 Shared package holds the state enum (IDLE, XFER) and the header-length field position constants.
REQ-035 One sub-module, rr_arbiter (NUM_CH-wide request/mask/last-grant to one-hot grant), is instantiated; all other logic lives in the top module.

Verification
REQ-036 After reset, ch0 holds header 0x03 plus 4 bytes, out_ready=1 -> 5 consecutive beats, sop on beat 1, eop on beat 5, fifo_pop[0] 5 cycles, busy then returns to 0.
REQ-037 All 3 channels hold 2-byte packets (header 0x00) -> grant order 0,1,2,0 with one IDLE cycle between packets.
REQ-038 Header 0x3F with out_ready toggling 1/0 -> exactly 65 pops, eop on the 65th accepted beat, out_data stable while stalled.
REQ-039 ch_en=3'b101 with all FIFOs non-empty -> ch1 is never granted; order is 0,2,0.
REQ-040 Mid-packet fifo_empty forced high for 3 cycles -> out_valid=0 and no pops for those cycles; the packet then resumes and completes with the correct count.
REQ-041 rst pulsed on beat 3 of a 6-byte packet -> the next cycle shows busy=0 and pops=0, and the next grant is ch0.

Source files
------------

// File: rtl/output_arbiter_pkg.sv
// Types and constants shared by the output arbiter and its round-robin grant logic.
package output_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  // The payload length field sits in the low bits of the header byte.
  localparam int LEN_LSB = 0;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/output_arbiter_rr_arbiter.sv
// Round-robin grant: the first requesting, unmasked channel after last_grant wins.
module rr_arbiter
  import output_arbiter_pkg::*;
#(
  parameter  int NUM_CH = 3,
  localparam int CH_WD  = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_WD-1:0]  last_grant,
  output logic [NUM_CH-1:0] grant
);

  logic [NUM_CH-1:0] elig;

  // Walk from the farthest candidate back to the nearest so the nearest one is kept.
  always_comb begin
    elig  = req & mask;
    grant = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (elig[(int'(last_grant) + k) % NUM_CH]) begin
        grant = '0;
        grant[(int'(last_grant) + k) % NUM_CH] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_arbiter.sv
// Serves whole packets (header, N payload bytes, CRC) from several channel FIFOs
// onto one ready/valid byte stream, one packet at a time, in round-robin order.
//   state | meaning
//   IDLE  | no packet in flight; pick the next channel
//   XFER  | streaming the packet of channel out_ch until its CRC byte
module output_arbiter
  import output_arbiter_pkg::*;
#(
  parameter  int NUM_CH  = 3,
  parameter  int DATA_WD = 8,
  parameter  int LEN_WD  = 6,
  localparam int CH_WD   = ch_width(NUM_CH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic [NUM_CH-1:0]         fifo_empty,
  input  logic [NUM_CH*DATA_WD-1:0] fifo_data,
  output logic [NUM_CH-1:0]         fifo_pop,
  output logic [DATA_WD-1:0]        out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic [CH_WD-1:0]          out_ch,
  output logic                      busy
);

  localparam logic [LEN_WD:0] CNT_ONE = {{LEN_WD{1'b0}}, 1'b1};

  state_t              state, state_nxt;
  logic [LEN_WD:0]     cnt;
  logic [CH_WD-1:0]    last_grant;
  logic [NUM_CH-1:0]   grant;
  logic [CH_WD-1:0]    grant_idx;
  logic                any_grant;
  logic                head_valid;
  logic                first_beat;
  logic                last_beat;
  logic                beat;
  logic [LEN_WD-1:0]   hdr_len;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .req        (~fifo_empty),
    .mask       (ch_en),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) grant_idx = CH_WD'(i);
    end
  end

  assign any_grant  = |grant;
  assign head_valid = !fifo_empty[out_ch];
  assign out_data   = fifo_data[int'(out_ch)*DATA_WD +: DATA_WD];
  assign hdr_len    = out_data[LEN_LSB +: LEN_WD];
  // A zero counter marks the header beat; it is back at zero after every CRC beat.
  assign first_beat = (cnt == '0);
  assign last_beat  = (cnt == CNT_ONE);
  assign beat       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_grant) state_nxt = XFER;
      XFER:    if (beat && last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are held low while rst is high so nothing is popped in the reset cycle.
  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    fifo_pop  = '0;
    if (state == XFER && !rst) begin
      busy             = 1'b1;
      out_valid        = head_valid;
      out_sop          = head_valid && first_beat;
      out_eop          = head_valid && last_beat;
      fifo_pop[out_ch] = head_valid && out_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      out_ch     <= '0;
      last_grant <= CH_WD'(NUM_CH - 1);
    end else begin
      if (state == IDLE && any_grant) out_ch <= grant_idx;
      if (beat) begin
        if (first_beat) cnt <= {1'b0, hdr_len} + CNT_ONE;
        else            cnt <= cnt - CNT_ONE;
        if (last_beat) last_grant <= out_ch;
      end
    end
  end

endmodule
